// File: rtl/stopwatch_display.sv
// BCD mm:ss stopwatch fed by a sampled divided clock, with 4-digit display scan.
// Optional lap freeze of the displayed value: define STOPWATCH_LAP_EN.
module stopwatch_display #(
  parameter int SCAN_DIV    = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        I_CLK,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] count,
  output logic        running,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync;
  logic        prev;
  logic        tick;
  logic        inc;
  logic [15:0] count_d;
  logic        ovf_d;
  logic [15:0] disp_d;

  logic [SW-1:0] scan;
  logic [1:0]    idx, idx_d;
  logic          scan_wrap;
  logic [3:0]    digit;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    unique case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // synchronise tick_in and keep its previous value for edge detect
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tick_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tick = sync[SYNC_STAGES-1] & ~prev;
  assign inc  = tick && (state == RUN) && !stop && !clear;

  // next state: clear beats stop beats start
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state == RUN) state_d = PAUSE;
    end else if (start) begin
      if (state != RUN) state_d = RUN;
    end
  end

  // BCD increment with full carry ripple and wrap at 59:59
  always_comb begin
    count_d = count;
    ovf_d   = overflow;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if (count[3:0] != 4'd9) begin
        count_d[3:0] = count[3:0] + 4'd1;
      end else begin
        count_d[3:0] = 4'd0;
        if (count[7:4] != 4'd5) begin
          count_d[7:4] = count[7:4] + 4'd1;
        end else begin
          count_d[7:4] = 4'd0;
          if (count[11:8] != 4'd9) begin
            count_d[11:8] = count[11:8] + 4'd1;
          end else begin
            count_d[11:8] = 4'd0;
            if (count[15:12] != 4'd5) begin
              count_d[15:12] = count[15:12] + 4'd1;
            end else begin
              count_d[15:12] = 4'd0;
              ovf_d          = 1'b1;
            end
          end
        end
      end
    end
  end

  // state, count and status registers
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      overflow <= ovf_d;
      running  <= (state_d == RUN);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        frozen, frozen_d;
  logic [15:0] latch, latch_d;

  // lap toggles freeze in RUN; stop/clear always unfreeze
  always_comb begin
    frozen_d = frozen;
    latch_d  = latch;
    if (clear || stop) begin
      frozen_d = 1'b0;
    end else if (lap && (state == RUN)) begin
      frozen_d = ~frozen;
    end
    if (frozen_d && !frozen) latch_d = count_d;
  end

  // lap latch registers
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      frozen <= 1'b0;
      latch  <= '0;
    end else begin
      frozen <= frozen_d;
      latch  <= latch_d;
    end
  end

  assign disp_d = frozen_d ? latch_d : count_d;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign disp_d     = count_d;
`endif

  assign scan_wrap = (scan == SCAN_MAX);
  assign idx_d     = scan_wrap ? idx + 2'd1 : idx;

  // pick the digit for the index being shown after this edge
  always_comb begin
    digit = disp_d[3:0];
    unique case (idx_d)
      2'd0: digit = disp_d[3:0];
      2'd1: digit = disp_d[7:4];
      2'd2: digit = disp_d[11:8];
      2'd3: digit = disp_d[15:12];
    endcase
  end

  // free-running scan with registered an/seg/dp
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      scan <= '0;
      idx  <= 2'd0;
      an   <= 4'b1110;
      seg  <= 7'b1000000;
      dp   <= 1'b1;
    end else begin
      scan <= scan_wrap ? '0 : scan + SW'(1);
      idx  <= idx_d;
      an   <= ~(4'b0001 << idx_d);
      seg  <= seg_of(digit);
      dp   <= (idx_d != 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: elapsed-seconds model + scoreboard.
// Build with +define+STOPWATCH_LAP_EN to also exercise the lap freeze.
module tb_stopwatch_display;

  localparam int SD = 4;
  localparam int SS = 2;

  logic I_CLK = 1'b0;
  logic rst_n = 1'b0;
  logic tick_in = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic [15:0] count;
  logic running, overflow, dp;
  logic [3:0] an;
  logic [6:0] seg;

  always #5 I_CLK = ~I_CLK;

  stopwatch_display #(.SCAN_DIV(SD), .SYNC_STAGES(SS)) dut (
    .I_CLK(I_CLK), .rst_n(rst_n), .tick_in(tick_in),
    .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(count), .running(running), .overflow(overflow),
    .an(an), .seg(seg), .dp(dp)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [15:0] bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] segpat(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d < 10) ? tbl[d] : 7'h7f;
  endfunction

  // model: 0 idle, 1 run, 2 pause; total = elapsed seconds
  int  m_state = 0;
  int  total = 0;
  bit  ovf = 0;
  int  cyc = 0;
  bit  hist [0:SS];
  bit  frozen = 0;
  logic [15:0] latch = '0;
  bit  model_on = 0;

  always @(posedge I_CLK) begin : model
    bit tk, inc;
    int old;
    if (!rst_n) begin
      m_state = 0; total = 0; ovf = 0; cyc = 0;
      frozen = 0; latch = '0;
      for (int i = 0; i <= SS; i++) hist[i] = 0;
      model_on = 1;
    end else if (model_on) begin
      old = m_state;
      tk  = hist[SS-1] && !hist[SS];
      for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = tick_in;
      inc = tk && old == 1 && !stop && !clear;
      if (clear) m_state = 0;
      else if (stop) begin if (old == 1) m_state = 2; end
      else if (start) m_state = 1;
      if (clear) begin
        total = 0; ovf = 0;
      end else if (inc) begin
        total = total + 1;
        if (total == 3600) begin total = 0; ovf = 1; end
      end
`ifdef STOPWATCH_LAP_EN
      if (clear || stop) frozen = 0;
      else if (lap && old == 1) begin
        frozen = !frozen;
        if (frozen) latch = bcd(total);
      end
`endif
      cyc = (cyc + 1) % (4 * SD);
    end
  end

  // scoreboard: every output, every cycle
  always @(negedge I_CLK) begin
    int idx;
    logic [15:0] d;
    logic [3:0] one, ea;
    if (model_on) begin
      idx = (cyc / SD) % 4;
      d   = frozen ? latch : bcd(total);
      one = 4'b0001;
      ea  = ~(one << idx);
      chk("cycle",
          {2'b0, count, running, overflow, an, seg, dp},
          {2'b0, bcd(total), m_state == 1, ovf, ea,
           segpat(d[idx*4 +: 4]), idx != 2});
    end
  end

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic pulse_clear();
    clear = 1; step(); clear = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_in = 1; step(); tick_in = 0; step();
    end
    repeat (4) step();
  endtask

  task automatic wait_an(input logic [3:0] want);
    int k;
    k = 0;
    while (an !== want && k < 40) begin step(); k++; end
    if (an !== want) chk("wait_an_timeout", {28'b0, an}, {28'b0, want});
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1;
    step();
    chk("rst_count", {16'b0, count}, 32'h0);
    chk("rst_flags", {30'b0, running, overflow}, 32'h0);
    chk("rst_an", {28'b0, an}, 32'he);
    chk("rst_seg", {25'b0, seg}, 32'h40);
    chk("rst_dp", {31'b0, dp}, 32'h1);

    pulse_start();
    tick_in = 1; step(); tick_in = 0; step();
    chk("lat_edge2", {16'b0, count}, 32'h0);
    step();
    chk("lat_edge3", {16'b0, count}, 32'h1);
    step();
    ticks(4);
    chk("five", {16'b0, count}, 32'h0005);
    chk("five_run", {31'b0, running}, 32'h1);

    pulse_clear(); pulse_start();
    ticks(59);
    chk("c0059", {16'b0, count}, 32'h0059);
    ticks(1);
    chk("c0100", {16'b0, count}, 32'h0100);
    ticks(539);
    chk("c0959", {16'b0, count}, 32'h0959);
    ticks(1);
    chk("c1000", {16'b0, count}, 32'h1000);
    ticks(2999);
    chk("c5959", {16'b0, count}, 32'h5959);
    ticks(1);
    chk("wrap", {15'b0, count, overflow}, {15'b0, 16'h0000, 1'b1});

    ticks(222);
    chk("c0342", {15'b0, count, overflow}, {15'b0, 16'h0342, 1'b1});
    pulse_clear();
    chk("clr", {14'b0, count, overflow, running}, 32'h0);
    ticks(3);
    chk("clr_idle", {16'b0, count}, 32'h0);

    pulse_start();
    ticks(12);
    chk("c0012", {16'b0, count}, 32'h0012);
    tick_in = 1; step(); tick_in = 0; step();
    stop = 1; step(); stop = 0;
    repeat (3) step();
    chk("stop_drop", {16'b0, count}, 32'h0012);
    chk("stop_pause", {31'b0, running}, 32'h0);
    pulse_start();
    ticks(1);
    chk("resume", {16'b0, count}, 32'h0013);

    pulse_clear(); pulse_start();
    ticks(754);
    chk("c1234", {16'b0, count}, 32'h1234);
    wait_an(4'b0111);
    wait_an(4'b1110);
    chk("scan0", {24'b0, an, seg, dp}, {24'b0, 4'b1110, 7'h19, 1'b1});
    repeat (SD) step();
    chk("scan1", {24'b0, an, seg, dp}, {24'b0, 4'b1101, 7'h30, 1'b1});
    repeat (SD) step();
    chk("scan2", {24'b0, an, seg, dp}, {24'b0, 4'b1011, 7'h24, 1'b0});
    repeat (SD) step();
    chk("scan3", {24'b0, an, seg, dp}, {24'b0, 4'b0111, 7'h79, 1'b1});

`ifdef STOPWATCH_LAP_EN
    pulse_clear(); pulse_start();
    ticks(20);
    lap = 1; step(); lap = 0;
    ticks(3);
    chk("lap_count", {16'b0, count}, 32'h0023);
    wait_an(4'b0111);
    wait_an(4'b1110);
    chk("lap_frozen", {25'b0, seg}, 32'h40);
    lap = 1; step(); lap = 0;
    wait_an(4'b0111);
    wait_an(4'b1110);
    chk("lap_live", {25'b0, seg}, 32'h30);
`endif

    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 15) == 0);
      stop    = ($urandom_range(0, 23) == 0);
      clear   = ($urandom_range(0, 63) == 0);
      lap     = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 499) != 0);
      step();
    end
    start = 0; stop = 0; clear = 0; lap = 0; rst_n = 1;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
